// File: rtl/simple_sig_pkg.sv
// Shared defaults and types for the simple_sig_link signal mirror.
package simple_sig_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_DELAY = 0;
  localparam int DEF_CNT_W = 16;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/simple_sig_delay.sv
// N-stage reset-to-0 register chain; collapses to a plain wire when DEPTH is 0
// so four-state values and sub-cycle pulses pass straight through.
module simple_sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset are deliberately ignored in the combinational mirror.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/simple_sig_link.sv
// Point-to-point signal mirror with a sampled copy, per-bit edge pulses and a
// saturating change counter for monitoring.
module simple_sig_link
  import simple_sig_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DELAY = DEF_DELAY,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_b,
  output logic [WIDTH-1:0] sig_a,
  output logic [WIDTH-1:0] sig_b_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] change_cnt
);

  logic [WIDTH-1:0] sig_b_d;
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  simple_sig_delay #(
    .WIDTH (WIDTH),
    .DEPTH (DELAY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (sig_b),
    .q   (sig_a)
  );

  always_comb begin
    sig_b_d = sig_b;
    rise_d  = sig_b & ~sig_b_q;
    fall_d  = ~sig_b & sig_b_q;
    cnt_d   = cnt_q;
    // Clear beats increment; the counter sticks at all-ones instead of wrapping.
    if (clr_cnt) begin
      cnt_d = '0;
    end else if ((sig_b != sig_b_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_b_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sig_b_q <= sig_b_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise       = rise_q;
  assign fall       = fall_q;
  assign change_cnt = cnt_q;

endmodule

// File: tb/tb_simple_sig_link.sv
// Directed scoreboard bench for simple_sig_link: combinational mirror, 2-deep
// delay, edge pulses, reset, and a 2-bit saturating counter.
module tb_simple_sig_link;
  import simple_sig_pkg::*;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst;

  logic sig_b0, sig_a0, q0, rise0, fall0, clr0;
  cnt_t cnt0;
  logic sig_b2, sig_a2, q2, rise2, fall2, clr2;
  cnt_t cnt2;
  logic sig_bs, sig_as, qs, rises, falls, clrs;
  logic [1:0] cnts;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] sb[$];
  logic [15:0] pq[$];

  always #5 clk = clk_en ? ~clk : 1'b0;

  simple_sig_link #(.WIDTH(1), .DELAY(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .sig_b(sig_b0), .sig_a(sig_a0), .sig_b_q(q0),
    .rise(rise0), .fall(fall0), .clr_cnt(clr0), .change_cnt(cnt0));

  simple_sig_link #(.WIDTH(1), .DELAY(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .sig_b(sig_b2), .sig_a(sig_a2), .sig_b_q(q2),
    .rise(rise2), .fall(fall2), .clr_cnt(clr2), .change_cnt(cnt2));

  simple_sig_link #(.WIDTH(1), .DELAY(0), .CNT_W(2)) u_s (
    .clk(clk), .rst(rst), .sig_b(sig_bs), .sig_a(sig_as), .sig_b_q(qs),
    .rise(rises), .fall(falls), .clr_cnt(clrs), .change_cnt(cnts));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [15:0] obs);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, sb.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic xv, zv;
    logic [3:0] seq4;
    logic [6:0] seq2;
    logic [15:0] cnt_exp [6];
    xv = 1'bx;
    zv = 1'bz;
    seq4 = 4'b0110;          // applied LSB first: 0,1,1,0
    seq2 = 7'b1110110;       // applied LSB first: 0,1,1,0,1,1,1
    cnt_exp = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};

    rst = 1'b1;
    sig_b0 = 1'b0; sig_b2 = 1'b0; sig_bs = 1'b0;
    clr0 = 1'b0; clr2 = 1'b0; clrs = 1'b0;
    #1;
    chk("rst_q2", 16'(q2), 16'h0);
    chk("rst_a2", 16'(sig_a2), 16'h0);
    chk("rst_cnt0", 16'(cnt0), 16'h0);
    chk("rst_rise0", 16'(rise0), 16'h0);
    sig_b0 = 1'b1;
    #1 chk("mirror_in_rst", 16'(sig_a0), 16'h1);

    // Combinational mirror with no clock at all
    sig_b0 = 1'b0;
    rst = 1'b0;
    #10 chk("mirror_0", 16'(sig_a0), 16'h0);
    sig_b0 = 1'b1;
    #10 chk("mirror_1", 16'(sig_a0), 16'h1);
    sig_b0 = xv;
    #1 chk("mirror_x", 16'(sig_a0), 16'(xv));
    sig_b0 = zv;
    #1 chk("mirror_z", 16'(sig_a0), 16'(zv));
    sig_b0 = 1'b0;
    #1 chk("mirror_back0", 16'(sig_a0), 16'h0);

    clk_en = 1'b1;
    tick();

    // Edge pulses and change counter on the 0,1,1,0 sequence
    for (int i = 0; i < 4; i++) begin
      sig_b0 = seq4[i];
      case (i)
        0: begin sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0); end
        1: begin sb.push_back(16'h1); sb.push_back(16'h1); sb.push_back(16'h0); sb.push_back(16'h1); end
        2: begin sb.push_back(16'h1); sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h1); end
        default: begin sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h1); sb.push_back(16'h2); end
      endcase
      tick();
      chk("edge_mirror", 16'(sig_a0), 16'(seq4[i]));
      sb_chk("edge_q", 16'(q0));
      sb_chk("edge_rise", 16'(rise0));
      sb_chk("edge_fall", 16'(fall0));
      sb_chk("edge_cnt", 16'(cnt0));
    end

    // Sub-period pulse: visible on the mirror, invisible to the sampled side
    sig_b0 = 1'b1;
    #1 chk("glitch_hi", 16'(sig_a0), 16'h1);
    #1 sig_b0 = 1'b0;
    #1 chk("glitch_lo", 16'(sig_a0), 16'h0);
    tick();
    chk("glitch_q", 16'(q0), 16'h0);
    chk("glitch_cnt", 16'(cnt0), 16'h2);

    // Two-stage delay: pipeline model pre-loaded with DELAY-1 reset zeros
    pq.push_back(16'h0);
    for (int i = 0; i < 7; i++) begin
      sig_b2 = seq2[i];
      pq.push_back(16'(seq2[i]));
      tick();
      chk("dly_a", 16'(sig_a2), pq.pop_front());
    end
    chk("dly_cnt", 16'(cnt2), 16'h3);

    // Mid-stream reset acts without a clock edge
    rst = 1'b1;
    #1;
    chk("mid_rst_a2", 16'(sig_a2), 16'h0);
    chk("mid_rst_q2", 16'(q2), 16'h0);
    chk("mid_rst_cnt2", 16'(cnt2), 16'h0);
    chk("mid_rst_cnt0", 16'(cnt0), 16'h0);
    sig_b0 = 1'b1;
    tick();
    chk("hold_rst_a2", 16'(sig_a2), 16'h0);
    chk("hold_rst_q0", 16'(q0), 16'h0);

    // Release with sig_b high: first edge compares against reset value 0
    rst = 1'b0;
    tick();
    chk("rel_q0", 16'(q0), 16'h1);
    chk("rel_rise0", 16'(rise0), 16'h1);
    chk("rel_cnt0", 16'(cnt0), 16'h1);
    tick();
    chk("rel_rise0_off", 16'(rise0), 16'h0);
    chk("rel_cnt0_hold", 16'(cnt0), 16'h1);

    // 2-bit counter saturation, then clear on a toggling edge
    for (int i = 0; i < 6; i++) begin
      sig_bs = ~sig_bs;
      sb.push_back(cnt_exp[i]);
      tick();
      sb_chk("sat_cnt", 16'(cnts));
    end
    chk("sat_fall", 16'(falls), 16'h1);
    sig_bs = ~sig_bs;
    clrs = 1'b1;
    sb.push_back(16'h0);
    tick();
    sb_chk("clr_wins", 16'(cnts));
    clrs = 1'b0;
    sig_bs = ~sig_bs;
    sb.push_back(16'h1);
    tick();
    sb_chk("after_clr", 16'(cnts));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simple_sig_link.md
Name: simple_sig_link

Overview:
- Point-to-point signal link carrying a driver-side value sig_b to a consumer-side mirror sig_a.
- Default configuration is a pure continuous mirror: sig_a equals sig_b in the same simulation time step, with no clock involvement.
- Adds a registered sampled copy, per-bit edge pulses and a saturating change counter for monitoring.
- Sits between a producer and consumer that share one interface bundle.

Parameters:
- WIDTH, 1, bit width of sig_b/sig_a.
- DELAY, 0, clock cycles sig_a lags sig_b; 0 = combinational mirror.
- CNT_W, 16, width of change counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig_b  input  WIDTH  driver-side value.
- sig_a  output  WIDTH  mirrored value.
- sig_b_q  output  WIDTH  sig_b registered once per clk.
- rise  output  WIDTH  per-bit one-cycle pulse, sampled bit went 0->1.
- fall  output  WIDTH  per-bit one-cycle pulse, sampled bit went 1->0.
- clr_cnt  input  1  synchronous clear of change_cnt.
- change_cnt  output  CNT_W  number of clock edges where sig_b_q changed value.

Behaviour:
- DELAY=0:
  - sig_a is a continuous assignment of sig_b, propagated in the same time step.
  - Four-state values (X/Z) pass unchanged.
  - rst and clk have no effect on sig_a.
- DELAY=N>0:
  - sig_a is the output of an N-stage register chain clocked by clk.
  - All stages reset to 0 asynchronously.
  - Latency is exactly N rising edges.
- Reset behaviour:
  - rst asserted, at any time including mid-operation, immediately forces sig_b_q, rise, fall, change_cnt and all pipeline stages to 0.
  - They hold 0 while rst is high.
- Sampling: each rising clk with rst low, sig_b_q <= sig_b.
- Edge pulses:
  - rise = sig_b & ~sig_b_q and fall = ~sig_b & sig_b_q, both registered on the same edge.
  - Each pulse is high for exactly one cycle per transition.
  - First edge after reset release compares against the reset value 0. Consequence: sig_b=1 at release gives rise=1 for one cycle.
- Counter:
  - Increments by 1 on an edge where sig_b != sig_b_q, regardless of how many bits differ.
  - Saturates at all-ones and never wraps.
- Counter clear:
  - clr_cnt=1 sets the counter to 0 on the edge.
  - Clear has priority over a simultaneous increment.
- A sig_b pulse shorter than one clock period:
  - still appears on sig_a when DELAY=0;
  - is missed by the sampled outputs.
- No handshake; the link never stalls.

Decomposition:
- Package simple_sig_pkg:
  - default WIDTH/DELAY/CNT_W localparams;
  - a typedef for the counter type.
- One sub-module, simple_sig_delay:
  - parameterised N-stage reset-to-0 register chain;
  - generate-bypassed to a wire when DELAY=0.
- Edge detect and counter live in the top.

Test Plan:
1. DELAY=0, rst=0, sig_b=0, wait 10 time units -> sig_a === 0; set sig_b=1, wait 10 -> sig_a === 1, with no clk toggling at all.
2. DELAY=0, sig_b=1'bx -> sig_a === 1'bx in the same time step; sig_b=1'bz -> sig_a === 1'bz.
3. DELAY=2, clocked, sig_b 0->1 just before edge k -> sig_a reads 1 after edge k+1 (two edges), 0 before; assert rst mid-stream -> sig_a, sig_b_q, change_cnt read 0 immediately, without a clock edge.
4. WIDTH=1, sig_b sequence 0,1,1,0 across four edges -> rise pulses one cycle after the 0->1 sample, fall one cycle after the 1->0 sample; change_cnt ends at 2.
5. CNT_W=2, toggle sig_b every edge for 6 edges -> change_cnt 1,2,3,3,3,3 (saturates); assert clr_cnt on a toggling edge -> change_cnt = 0 (clear wins).
6. Release rst with sig_b=1 -> first edge gives sig_b_q=1, rise=1 for one cycle, change_cnt=1.
